// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcodes, funct codes, mux selects.
// Define MC_CTRL_BNE_EN to add the BRANCHNE state for bne.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10,
`ifdef MC_CTRL_BNE_EN
        S_BRANCHNE = 4'd12,
`endif
        S_JUMP     = 4'd11
    } statetype;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALURESULT = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT    = 2'b01;
    localparam logic [1:0] PCSRC_JUMP      = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_aludec.sv
// ALU decoder: maps the FSM's aluop and the instruction funct field to an ALU control code.
module aludec
    import mc_ctrl_pkg::*;
(
    input  logic [1:0] aluop_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alucontrol_o
);

    always_comb begin
        alucontrol_o = ALU_ADD;
        case (aluop_i)
            ALUOP_ADD: alucontrol_o = ALU_ADD;
            ALUOP_SUB: alucontrol_o = ALU_SUB;
            default: begin
                // Unknown funct codes fall back to add without flagging anything.
                case (funct_i)
                    FUNCT_SUB: alucontrol_o = ALU_SUB;
                    FUNCT_AND: alucontrol_o = ALU_AND;
                    FUNCT_OR:  alucontrol_o = ALU_OR;
                    FUNCT_SLT: alucontrol_o = ALU_SLT;
                    default:   alucontrol_o = ALU_ADD;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore sequencing FSM for the multicycle MIPS datapath with a req/ready memory handshake.
// Optional MC_CTRL_BNE_EN adds bne support via a BRANCHNE state.
module multicycle_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       pcen,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       instr_done,
    output logic       illegal_op
);

    statetype   state_q, state_d;
    logic [1:0] aluop;
    logic       pcwrite;
    logic       branch;
    logic       branchne;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
`ifdef MC_CTRL_BNE_EN
                    OP_BNE:       state_d = S_BRANCHNE;
`endif
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTE:  state_d = S_ALUWB;
            S_ADDIEX:   state_d = S_ADDIWB;
            default:    state_d = S_FETCH;
        endcase
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        mem_req    = 1'b0;
        iord       = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        branchne   = 1'b0;
        regwrite   = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = SRCB_B;
        pcsrc      = PCSRC_ALURESULT;
        aluop      = ALUOP_ADD;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                irwrite = mem_ready;
                pcwrite = mem_ready;
                alusrcb = SRCB_FOUR;
            end
            S_DECODE: begin
                alusrcb = SRCB_IMMSH2;
                case (op)
                    OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: illegal_op = 1'b0;
`ifdef MC_CTRL_BNE_EN
                    OP_BNE:  illegal_op = 1'b0;
`endif
                    default: illegal_op = 1'b1;
                endcase
            end
            S_MEMADR, S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWB: begin
                memtoreg   = 1'b1;
                regwrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req    = 1'b1;
                iord       = 1'b1;
                memwrite   = 1'b1;
                instr_done = mem_ready;
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                regdst     = 1'b1;
                regwrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_ADDIWB: begin
                regwrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                aluop      = ALUOP_SUB;
                pcsrc      = PCSRC_ALUOUT;
                branch     = 1'b1;
                instr_done = 1'b1;
            end
`ifdef MC_CTRL_BNE_EN
            S_BRANCHNE: begin
                alusrca    = 1'b1;
                aluop      = ALUOP_SUB;
                pcsrc      = PCSRC_ALUOUT;
                branchne   = 1'b1;
                instr_done = 1'b1;
            end
`endif
            S_JUMP: begin
                pcsrc      = PCSRC_JUMP;
                pcwrite    = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
        // The state register already holds FETCH in reset; this also blocks the
        // mem_ready-qualified enables from reaching the datapath while reset is low.
        if (!reset) begin
            irwrite  = 1'b0;
            pcwrite  = 1'b0;
            branch   = 1'b0;
            branchne = 1'b0;
            regwrite = 1'b0;
            memwrite = 1'b0;
        end
    end

    assign pcen = pcwrite | (branch & zero) | (branchne & ~zero);

    aludec u_aludec (
        .aluop_i      (aluop),
        .funct_i      (funct),
        .alucontrol_o (alucontrol)
    );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: each instruction is expanded into a per-cycle list of
// expected outputs from the instruction-level timing rules, then played against the DUT.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] op = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, iord, memwrite, irwrite, pcen, regwrite, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic       instr_done, illegal_op;

    multicycle_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .iord       (iord),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .pcen       (pcen),
        .regwrite   (regwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol),
        .instr_done (instr_done),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_req, iord, memwrite, irwrite, pcen, regwrite, regdst, memtoreg, alusrca;
        logic [1:0] alusrcb, pcsrc;
        logic [2:0] alucontrol;
        logic       instr_done, illegal_op;
    } outs_t;

    typedef struct packed {
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        logic       rdy;
        outs_t      exp;
    } cyc_t;

    cyc_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   instr_no = 0;

    logic [5:0] cur_op, cur_funct;
    logic       cur_zero;

    function automatic outs_t idle();
        outs_t o = '0;
        o.alucontrol = 3'b010;
        return o;
    endfunction

    function automatic logic [2:0] alu_for(input logic [5:0] f);
        case (f)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic outs_t sample();
        outs_t o;
        o.mem_req = mem_req;     o.iord = iord;         o.memwrite = memwrite;
        o.irwrite = irwrite;     o.pcen = pcen;         o.regwrite = regwrite;
        o.regdst = regdst;       o.memtoreg = memtoreg; o.alusrca = alusrca;
        o.alusrcb = alusrcb;     o.pcsrc = pcsrc;       o.alucontrol = alucontrol;
        o.instr_done = instr_done; o.illegal_op = illegal_op;
        return o;
    endfunction

    task automatic check(input string tag, input outs_t got, input outs_t want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s instr=%0d op=%b got=%h want=%h", tag, instr_no, op, got, want);
        end
    endtask

    task automatic push(input logic rdy, input outs_t o);
        cyc_t c;
        c.op = cur_op; c.funct = cur_funct; c.zero = cur_zero; c.rdy = rdy; c.exp = o;
        q.push_back(c);
    endtask

    // A memory access of n stall cycles: n cycles with mem_ready low, then one completing cycle.
    task automatic push_access(input int waits, input outs_t o_wait, input outs_t o_done);
        for (int i = 0; i < waits; i++) push(1'b0, o_wait);
        push(1'b1, o_done);
    endtask

    task automatic plan(input logic [5:0] op_v, input logic [5:0] f_v, input logic z_v,
                        input int fetch_waits, input int mem_waits);
        outs_t o, od;
        bit    bne_en, legal;
`ifdef MC_CTRL_BNE_EN
        bne_en = 1'b1;
`else
        bne_en = 1'b0;
`endif
        cur_op = op_v; cur_funct = f_v; cur_zero = z_v;
        o = idle(); o.mem_req = 1'b1; o.alusrcb = 2'b01;
        od = o; od.irwrite = 1'b1; od.pcen = 1'b1;
        push_access(fetch_waits, o, od);

        legal = (op_v inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010})
                || (bne_en && op_v == 6'b000101);
        o = idle(); o.alusrcb = 2'b11; o.illegal_op = !legal;
        push(1'($urandom_range(0, 1)), o);
        if (legal) begin
            case (op_v)
                6'b100011, 6'b101011: begin
                    o = idle(); o.alusrca = 1'b1; o.alusrcb = 2'b10;
                    push(1'($urandom_range(0, 1)), o);
                    o = idle(); o.mem_req = 1'b1; o.iord = 1'b1;
                    if (op_v == 6'b100011) begin
                        push_access(mem_waits, o, o);
                        o = idle(); o.memtoreg = 1'b1; o.regwrite = 1'b1; o.instr_done = 1'b1;
                        push(1'($urandom_range(0, 1)), o);
                    end else begin
                        o.memwrite = 1'b1;
                        od = o; od.instr_done = 1'b1;
                        push_access(mem_waits, o, od);
                    end
                end
                6'b000000: begin
                    o = idle(); o.alusrca = 1'b1; o.alucontrol = alu_for(f_v);
                    push(1'($urandom_range(0, 1)), o);
                    o = idle(); o.regdst = 1'b1; o.regwrite = 1'b1; o.instr_done = 1'b1;
                    push(1'($urandom_range(0, 1)), o);
                end
                6'b001000: begin
                    o = idle(); o.alusrca = 1'b1; o.alusrcb = 2'b10;
                    push(1'($urandom_range(0, 1)), o);
                    o = idle(); o.regwrite = 1'b1; o.instr_done = 1'b1;
                    push(1'($urandom_range(0, 1)), o);
                end
                6'b000010: begin
                    o = idle(); o.pcsrc = 2'b10; o.pcen = 1'b1; o.instr_done = 1'b1;
                    push(1'($urandom_range(0, 1)), o);
                end
                default: begin
                    // beq takes the branch on zero, bne on not-zero
                    o = idle(); o.alusrca = 1'b1; o.alucontrol = 3'b110; o.pcsrc = 2'b01;
                    o.instr_done = 1'b1;
                    o.pcen = (op_v == 6'b000100) ? z_v : !z_v;
                    push(1'($urandom_range(0, 1)), o);
                end
            endcase
        end
    endtask

    task automatic run(input int limit);
        int n = 0;
        while (q.size() > 0 && n < limit) begin
            cyc_t c = q.pop_front();
            @(negedge clk);
            op = c.op; funct = c.funct; zero = c.zero; mem_ready = c.rdy;
            #1;
            check($sformatf("cycle%0d", n), sample(), c.exp);
            n++;
        end
        q.delete();
        instr_no++;
    endtask

    task automatic check_reset_cycle(input string tag);
        outs_t o;
        @(negedge clk);
        reset = 1'b0; mem_ready = 1'b1;
        #1;
        o = idle(); o.mem_req = 1'b1; o.alusrcb = 2'b01;
        check(tag, sample(), o);
    endtask

    function automatic logic [5:0] rand_illegal();
        logic [5:0] v;
        do v = 6'($urandom);
        while (v inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b000101});
        return v;
    endfunction

    initial begin
        logic [5:0] legal_f[5];
        logic [5:0] ops[7];
        legal_f = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b000101};

        for (int i = 0; i < 3; i++) check_reset_cycle($sformatf("reset%0d", i));
        @(posedge clk); #1 reset = 1'b1;

        plan(6'b100011, 6'd0, 1'b0, 0, 0); run(100);    // lw, zero wait
        plan(6'b101011, 6'd0, 1'b0, 0, 2); run(100);    // sw, 2 stalls in MEMWRITE
        plan(6'b000000, 6'b101010, 1'b0, 1, 0); run(100);
        plan(6'b000100, 6'd0, 1'b1, 0, 0); run(100);
        plan(6'b000100, 6'd0, 1'b0, 0, 0); run(100);
        plan(6'b000101, 6'd0, 1'b1, 0, 0); run(100);
        plan(6'b000101, 6'd0, 1'b0, 0, 0); run(100);
        plan(6'b111111, 6'd0, 1'b0, 0, 0); run(100);
        plan(6'b001000, 6'd0, 1'b0, 2, 0); run(100);
        plan(6'b000010, 6'd0, 1'b0, 0, 0); run(100);
        plan(6'b000000, 6'b110011, 1'b1, 0, 0); run(100); // unknown funct -> add

        for (int i = 0; i < 80; i++) begin
            int k = $urandom_range(0, 7);
            logic [5:0] o_v = (k == 7) ? rand_illegal() : ops[k];
            logic [5:0] f_v = ($urandom_range(0, 2) != 0) ? legal_f[$urandom_range(0, 4)] : 6'($urandom);
            plan(o_v, f_v, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 2));
            run(100);
        end

        // Abort a lw in MEMREAD: no writeback, restart from FETCH.
        plan(6'b100011, 6'd0, 1'b0, 0, 0); run(3);
        check_reset_cycle("abort_in_reset");
        @(posedge clk); #1 reset = 1'b1;
        plan(6'b001000, 6'd0, 1'b0, 0, 0); run(100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
